pcie_tl_rx: RTL and testbench

Receive-side PCIe Transaction Layer. Accepts 256-bit TLPs (128-bit 4DW header + 128-bit payload) from the Data Link Layer, validates them as single-beat Memory Writes, and buffers good TLPs into per-VC FIFOs selected by TC[0]. A round-robin arbiter drains the FIFOs into an AXI4 write master (AW/W/B). The block returns one flow-control credit per VC slot freed; it mirrors the TX Transaction Layer on the far end of the link.

---
 rtl/pcie_tl_rx.sv | 167 ++++++++++++++++
 tb/tb_pcie_tl_rx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tl_rx.sv
// Receive-side PCIe Transaction Layer: validates single-beat MWr TLPs, buffers them per VC,
// and drains them round-robin into an AXI4 write master with per-VC credit return.
module pcie_tl_rx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tlp_valid_i,
  input  logic [255:0]        tlp_i,
  output logic                tlp_ready_o,
  output logic                aw_valid_o,
  input  logic                aw_ready_i,
  output logic [ADDR_W-1:0]   aw_addr_o,
  output logic                w_valid_o,
  input  logic                w_ready_i,
  output logic [DATA_W-1:0]   w_data_o,
  output logic [DATA_W/8-1:0] w_strb_o,
  output logic                w_last_o,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [1:0]          b_resp_i,
  output logic                fc_credit_vc0_o,
  output logic                fc_credit_vc1_o,
  output logic                drop_pulse_o,
  output logic                axi_err_o,
  output logic [15:0]         drop_cnt_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = ADDR_W + DATA_W;
  localparam logic [PW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  logic [127:0]      hdr;
  logic [63:0]       tlp_addr;
  logic              tlp_good;
  logic              tlp_acc;
  logic [1:0]        wr_en;
  logic [1:0]        rd_en;
  logic [1:0]        full;
  logic [1:0]        empty;
  logic              sel_vc;
  logic              pop_any;
  logic [EW-1:0]     head;
  logic [PW:0]       wr_ptr [2];
  logic [PW:0]       rd_ptr [2];
  logic [EW-1:0]     mem    [2][FIFO_DEPTH];
  state_t            state;
  logic              last_vc;
  logic              unused_hdr_bits;

  assign hdr      = tlp_i[255:128];
  assign tlp_addr = {hdr[63:2], 2'b00};
  assign tlp_good = (hdr[127:125] == 3'b011) && (hdr[124:120] == 5'b00000) &&
                    (hdr[105:96] == 10'd4);
  assign unused_hdr_bits = ^{hdr[119:117], hdr[115:106], hdr[95:64], hdr[1:0]};

  assign tlp_ready_o = !full[0] && !full[1];
  assign tlp_acc     = tlp_valid_i && tlp_ready_o;
  assign wr_en[0]    = tlp_acc && tlp_good && !hdr[116];
  assign wr_en[1]    = tlp_acc && tlp_good &&  hdr[116];

  always_comb begin
    full  = '0;
    empty = '0;
    for (int unsigned v = 0; v < 2; v++) begin
      empty[v] = (wr_ptr[v] == rd_ptr[v]);
      full[v]  = (wr_ptr[v][PW] != rd_ptr[v][PW]) &&
                 (wr_ptr[v][PW-1:0] == rd_ptr[v][PW-1:0]);
    end
  end

  // VC1 wins only when it alone has data, or both do and VC0 was served last.
  assign sel_vc  = !empty[1] && (empty[0] || !last_vc);
  assign pop_any = (state == IDLE) && !(empty[0] && empty[1]);
  assign rd_en[0] = pop_any && !sel_vc;
  assign rd_en[1] = pop_any &&  sel_vc;
  assign head     = mem[sel_vc][rd_ptr[sel_vc][PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned v = 0; v < 2; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
      end
    end else begin
      for (int unsigned v = 0; v < 2; v++) begin
        if (wr_en[v]) wr_ptr[v] <= wr_ptr[v] + PTR_ONE;
        if (rd_en[v]) rd_ptr[v] <= rd_ptr[v] + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < 2; v++) begin
      if (wr_en[v]) mem[v][wr_ptr[v][PW-1:0]] <= {tlp_addr[ADDR_W-1:0], tlp_i[DATA_W-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse_o <= 1'b0;
      drop_cnt_o   <= '0;
    end else begin
      drop_pulse_o <= tlp_acc && !tlp_good;
      if (tlp_acc && !tlp_good && (drop_cnt_o != 16'hFFFF))
        drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  assign w_strb_o = '1;
  assign w_last_o = 1'b1;

  // The valid registers double as the per-channel "not yet done" flags in XFER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_vc         <= 1'b1;
      aw_valid_o      <= 1'b0;
      w_valid_o       <= 1'b0;
      b_ready_o       <= 1'b0;
      aw_addr_o       <= '0;
      w_data_o        <= '0;
      fc_credit_vc0_o <= 1'b0;
      fc_credit_vc1_o <= 1'b0;
      axi_err_o       <= 1'b0;
    end else begin
      fc_credit_vc0_o <= 1'b0;
      fc_credit_vc1_o <= 1'b0;
      axi_err_o       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop_any) begin
            aw_addr_o       <= head[EW-1:DATA_W];
            w_data_o        <= head[DATA_W-1:0];
            last_vc         <= sel_vc;
            fc_credit_vc0_o <= !sel_vc;
            fc_credit_vc1_o <= sel_vc;
            aw_valid_o      <= 1'b1;
            w_valid_o       <= 1'b1;
            state           <= XFER;
          end
        end
        XFER: begin
          if (aw_valid_o && aw_ready_i) aw_valid_o <= 1'b0;
          if (w_valid_o && w_ready_i)   w_valid_o  <= 1'b0;
          if ((!aw_valid_o || aw_ready_i) && (!w_valid_o || w_ready_i)) begin
            b_ready_o <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (b_valid_i) begin
            b_ready_o <= 1'b0;
            axi_err_o <= (b_resp_i != 2'b00);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_tl_rx.sv
// Directed bench for pcie_tl_rx: latency, drop handling, backpressure, arbitration,
// AXI error response and mid-transaction reset.
module tb_pcie_tl_rx;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tlp_valid_i;
  logic [255:0] tlp_i;
  logic         tlp_ready_o;
  logic         aw_valid_o, aw_ready_i;
  logic [63:0]  aw_addr_o;
  logic         w_valid_o, w_ready_i;
  logic [127:0] w_data_o;
  logic [15:0]  w_strb_o;
  logic         w_last_o;
  logic         b_valid_i, b_ready_o;
  logic [1:0]   b_resp_i;
  logic         fc_credit_vc0_o, fc_credit_vc1_o;
  logic         drop_pulse_o, axi_err_o;
  logic [15:0]  drop_cnt_o;
  logic         b_auto;

  int total = 0;
  int bad   = 0;

  int aw_n = 0, w_n = 0, b_n = 0, c0_n = 0, c1_n = 0, err_n = 0;
  logic [63:0]  aw_log [$];
  logic [127:0] w_log  [$];

  pcie_tl_rx #(.FIFO_DEPTH(4), .ADDR_W(64), .DATA_W(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .tlp_valid_i(tlp_valid_i), .tlp_i(tlp_i), .tlp_ready_o(tlp_ready_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
    .w_strb_o(w_strb_o), .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .fc_credit_vc0_o(fc_credit_vc0_o), .fc_credit_vc1_o(fc_credit_vc1_o),
    .drop_pulse_o(drop_pulse_o), .axi_err_o(axi_err_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  // Slave answers B on the first cycle b_ready_o is offered.
  assign b_valid_i = b_auto && b_ready_o;

  always @(posedge clk) begin
    if (aw_valid_o && aw_ready_i) begin aw_log.push_back(aw_addr_o); aw_n <= aw_n + 1; end
    if (w_valid_o && w_ready_i)   begin w_log.push_back(w_data_o);   w_n  <= w_n + 1;  end
    if (b_valid_i && b_ready_o)   b_n <= b_n + 1;
    if (fc_credit_vc0_o) c0_n <= c0_n + 1;
    if (fc_credit_vc1_o) c1_n <= c1_n + 1;
    if (axi_err_o)       err_n <= err_n + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk(input logic [2:0] fmt, input logic [4:0] typ,
                                      input logic [2:0] tc, input logic [9:0] len,
                                      input logic [63:0] addr, input logic [127:0] pl);
    logic [127:0] h;
    h = '0;
    h[127:125] = fmt;
    h[124:120] = typ;
    h[118:116] = tc;
    h[105:96]  = len;
    h[63:2]    = addr[63:2];
    return {h, pl};
  endfunction

  function automatic logic [127:0] aw_at(input int i);
    if (i < aw_log.size()) return {64'd0, aw_log[i]};
    return '1;
  endfunction

  function automatic logic [127:0] w_at(input int i);
    if (i < w_log.size()) return w_log[i];
    return '1;
  endfunction

  task automatic push(input logic tc0, input logic [63:0] addr, input logic [127:0] pl);
    tlp_valid_i = 1'b1;
    tlp_i = mk(3'b011, 5'b00000, {2'b00, tc0}, 10'd4, addr, pl);
    tick();
    tlp_valid_i = 1'b0;
  endtask

  task automatic wait_b(input string tag, input int target, input int maxc);
    for (int i = 0; i < maxc && b_n < target; i++) tick();
    check(tag, 128'(b_n), 128'(target));
  endtask

  initial begin
    int a0, c0s, c1s, bs, es, acc;
    logic was_ready;

    rst_n = 1'b0; tlp_valid_i = 1'b0; tlp_i = '0;
    aw_ready_i = 1'b0; w_ready_i = 1'b0; b_resp_i = 2'b00; b_auto = 1'b1;
    tick(); tick();
    check("rst_ready",  128'(tlp_ready_o), 128'd1);
    check("rst_awv",    128'(aw_valid_o),  128'd0);
    check("rst_wv",     128'(w_valid_o),   128'd0);
    check("rst_bready", 128'(b_ready_o),   128'd0);
    check("rst_awaddr", 128'(aw_addr_o),   128'd0);
    check("rst_wdata",  w_data_o,          128'd0);
    check("rst_dcnt",   128'(drop_cnt_o),  128'd0);
    check("rst_pulses", 128'({fc_credit_vc0_o, fc_credit_vc1_o, drop_pulse_o, axi_err_o}), 128'd0);
    check("strb_last",  128'({w_strb_o, w_last_o}), 128'h1FFFF);
    rst_n = 1'b1;
    tick();

    // Single MWr, tc=0, slave always ready
    aw_ready_i = 1'b1; w_ready_i = 1'b1;
    c0s = c0_n; c1s = c1_n;
    push(1'b0, 64'h1000, {4{32'hA5A5_A5A5}});
    check("t1_awv_e0", 128'(aw_valid_o), 128'd0);
    tick();
    check("t1_awv",    128'(aw_valid_o), 128'd1);
    check("t1_wv",     128'(w_valid_o),  128'd1);
    check("t1_addr",   128'(aw_addr_o),  128'h1000);
    check("t1_data",   w_data_o,         {4{32'hA5A5_A5A5}});
    check("t1_cred0",  128'(fc_credit_vc0_o), 128'd1);
    check("t1_cred1",  128'(fc_credit_vc1_o), 128'd0);
    tick();
    check("t1_awv_off", 128'(aw_valid_o), 128'd0);
    check("t1_cred_off", 128'(fc_credit_vc0_o), 128'd0);
    check("t1_bready", 128'(b_ready_o), 128'd1);
    tick();
    check("t1_idle",   128'(b_ready_o), 128'd0);
    check("t1_c0cnt",  128'(c0_n - c0s), 128'd1);
    check("t1_c1cnt",  128'(c1_n - c1s), 128'd0);

    // Malformed TLPs back to back
    a0 = aw_n;
    tlp_valid_i = 1'b1;
    tlp_i = mk(3'b010, 5'b00000, 3'd0, 10'd4, 64'h1100, '0);
    tick();
    check("m1_pulse", 128'(drop_pulse_o), 128'd1);
    check("m1_cnt",   128'(drop_cnt_o),   128'd1);
    check("m1_ready", 128'(tlp_ready_o),  128'd1);
    tlp_i = mk(3'b011, 5'b00000, 3'd0, 10'd8, 64'h1200, '0);
    tick();
    tlp_valid_i = 1'b0;
    check("m2_pulse", 128'(drop_pulse_o), 128'd1);
    check("m2_cnt",   128'(drop_cnt_o),   128'd2);
    tick();
    check("m_pulse_off", 128'(drop_pulse_o), 128'd0);
    repeat (4) tick();
    check("m_no_aw",  128'(aw_n - a0), 128'd0);
    check("m_awv",    128'(aw_valid_o), 128'd0);
    check("m_ready",  128'(tlp_ready_o), 128'd1);

    // Backpressure: 9 offered on VC1, AXI stalled
    aw_ready_i = 1'b0; w_ready_i = 1'b0;
    a0 = aw_log.size(); c0s = c0_n; c1s = c1_n; bs = b_n;
    acc = 0;
    for (int cyc = 0; cyc < 12 && acc < 9; cyc++) begin
      tlp_valid_i = 1'b1;
      tlp_i = mk(3'b011, 5'b00000, 3'd1, 10'd4, 64'h2000 + 64'(acc * 16),
                 {4{32'hB000_0000 + 32'(acc)}});
      was_ready = tlp_ready_o;
      tick();
      if (was_ready) acc++;
    end
    tlp_valid_i = 1'b0;
    check("bp_accepts", 128'(acc), 128'd5);
    check("bp_ready",   128'(tlp_ready_o), 128'd0);
    check("bp_awv",     128'(aw_valid_o), 128'd1);
    check("bp_addr0",   128'(aw_addr_o), 128'h2000);
    aw_ready_i = 1'b1; w_ready_i = 1'b1;
    wait_b("bp_done", bs + 5, 80);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_aw%0d", i), aw_at(a0 + i), 128'h2000 + 128'(i * 16));
      check($sformatf("bp_w%0d", i),  w_at(a0 + i),  {4{32'hB000_0000 + 32'(i)}});
    end
    check("bp_c1cnt",  128'(c1_n - c1s), 128'd5);
    check("bp_c0cnt",  128'(c0_n - c0s), 128'd0);
    check("bp_ready2", 128'(tlp_ready_o), 128'd1);

    // Arbitration: A0 in flight, then A1/B0/B1 buffered
    aw_ready_i = 1'b0; w_ready_i = 1'b0;
    a0 = aw_log.size(); bs = b_n;
    push(1'b0, 64'h3000, {4{32'hAAAA_0000}});
    push(1'b0, 64'h3010, {4{32'hAAAA_0001}});
    push(1'b1, 64'h4000, {4{32'hBBBB_0000}});
    push(1'b1, 64'h4010, {4{32'hBBBB_0001}});
    aw_ready_i = 1'b1; w_ready_i = 1'b1;
    wait_b("arb_done", bs + 4, 60);
    check("arb_0", aw_at(a0),     128'h3000);
    check("arb_1", aw_at(a0 + 1), 128'h4000);
    check("arb_2", aw_at(a0 + 2), 128'h3010);
    check("arb_3", aw_at(a0 + 3), 128'h4010);
    check("arb_w1", w_at(a0 + 1), {4{32'hBBBB_0000}});

    // AW three cycles ahead of W, SLVERR response
    aw_ready_i = 1'b1; w_ready_i = 1'b0; b_resp_i = 2'b10;
    a0 = aw_log.size(); es = err_n; bs = b_n;
    push(1'b0, 64'h5000, {4{32'hC0C0_C0C0}});
    tick();
    check("e_awv",   128'(aw_valid_o), 128'd1);
    check("e_wv",    128'(w_valid_o),  128'd1);
    tick();
    check("e_awv_done", 128'(aw_valid_o), 128'd0);
    check("e_wv_hold",  128'(w_valid_o),  128'd1);
    tick(); tick();
    check("e_wv_hold2", 128'(w_valid_o), 128'd1);
    check("e_no_bready", 128'(b_ready_o), 128'd0);
    w_ready_i = 1'b1;
    tick();
    check("e_wv_done", 128'(w_valid_o), 128'd0);
    check("e_bready",  128'(b_ready_o), 128'd1);
    tick();
    check("e_err_pulse", 128'(axi_err_o), 128'd1);
    tick();
    check("e_err_off", 128'(axi_err_o), 128'd0);
    b_resp_i = 2'b00;
    check("e_aw_count", 128'(aw_log.size() - a0), 128'd1);
    push(1'b1, 64'h6000, {4{32'hD0D0_D0D0}});
    wait_b("e_next_done", bs + 2, 20);
    check("e_next_addr", aw_at(a0 + 1), 128'h6000);
    check("e_err_cnt",   128'(err_n - es), 128'd1);

    // Reset during XFER with three entries buffered
    aw_ready_i = 1'b0; w_ready_i = 1'b0;
    push(1'b0, 64'h7000, {4{32'h7000_0000}});
    push(1'b1, 64'h7010, {4{32'h7010_0000}});
    push(1'b0, 64'h7020, {4{32'h7020_0000}});
    push(1'b1, 64'h7030, {4{32'h7030_0000}});
    tick();
    check("r_inflight", 128'(aw_valid_o), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("r_awv",    128'(aw_valid_o), 128'd0);
    check("r_wv",     128'(w_valid_o),  128'd0);
    check("r_bready", 128'(b_ready_o),  128'd0);
    check("r_addr",   128'(aw_addr_o),  128'd0);
    check("r_data",   w_data_o,         128'd0);
    check("r_ready",  128'(tlp_ready_o), 128'd1);
    check("r_dcnt",   128'(drop_cnt_o), 128'd0);
    a0 = aw_log.size(); c0s = c0_n; c1s = c1_n; bs = b_n;
    aw_ready_i = 1'b1; w_ready_i = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("r_no_aw",    128'(aw_log.size() - a0), 128'd0);
    check("r_no_cred",  128'((c0_n - c0s) + (c1_n - c1s)), 128'd0);
    push(1'b1, 64'h8000, {4{32'h8888_8888}});
    wait_b("r_new_done", bs + 1, 20);
    check("r_new_addr", aw_at(a0), 128'h8000);
    check("r_new_data", w_at(a0),  {4{32'h8888_8888}});
    check("r_new_c1",   128'(c1_n - c1s), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
